ceespu_fetch: RTL and testbench
===============================

Name: ceespu_fetch

Overview:
- Parametrised successor to the core's PC block: holds the fetch PC, issues instruction-memory reads and buffers returned instructions with their PCs in a prefetch queue.
- Presents one instruction per cycle to decode over a valid/ready handshake instead of a raw stall wire.
- Sits between instruction memory and decode; execute drives branch redirects, which flush the queue and any in-flight read.

Parameters:
- PC_W, 14, word-address width of PC; byte address is {PC, 2'b00}.
- INSTR_W, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, >= 2.
- RESET_PC, 0, word address loaded on reset.

Ports:
- I_clk  in  1  clock, rising edge.
- I_rst  in  1  asynchronous, active-low reset (asserted when 0).
- I_branch  in  1  redirect request from execute.
- I_branchAddress  in  PC_W  redirect target, word address.
- O_imemAddress  out  PC_W+2  byte address to imem; bits [1:0] are always 0.
- O_imemE  out  1  imem read enable.
- I_imemData  in  INSTR_W  read data, valid exactly 1 cycle after an O_imemE cycle.
- O_valid  out  1  queue head is valid.
- I_ready  in  1  decode accepts head.
- O_instr  out  INSTR_W  head instruction.
- O_instrPC  out  PC_W  head PC.
- O_fetchCount  out  32  instructions delivered (feature-dependent).
- O_flushCount  out  16  redirects taken (feature-dependent).

Behaviour:
- Reset (I_rst=0, asynchronous): PC=RESET_PC; queue empty; in-flight flag=0; O_valid=0; O_imemE=0; O_instr=0; O_instrPC=0; counters=0.
- Pop: occurs when O_valid && I_ready. O_instr and O_instrPC stay stable while O_valid && !I_ready.
- Issue rule: O_imemE=1 in a cycle iff !I_branch and (count + inflight - pop) < DEPTH.
  - On issue: O_imemAddress={PC,2'b00}; PC<=PC+1, wrapping modulo 2^PC_W.
- Response: the cycle after an issue, I_imemData plus the issued PC are pushed at the queue tail, unless discarded (see redirect).
- Latency and throughput:
  - Instruction issued at cycle t appears at the head (O_valid=1) at t+2 when the queue is empty.
  - Sustained throughput is 1 instruction/cycle when I_ready stays high.
- Redirect: I_branch=1 in cycle t:
  - Queue flushed at the edge ending t.
  - Any response arriving at t+1 is dropped.
  - PC<=I_branchAddress; no issue in cycle t.
  - Target issued at t+1; O_valid=0 during t+1..t+2; target at head at t+3.
- Simultaneous events:
  - Branch and pop in the same cycle: the pop counts for handshake and counters, then the flush applies.
  - Push and pop in the same cycle with the queue full: both are legal and occupancy is unchanged.
- Overflow is impossible by the issue rule. A push into a full queue is an assertion failure.
- Reset mid-operation: all state clears immediately. The first issue after deassertion is at the first clock edge with I_rst=1, address RESET_PC.

Optional Feature:
- Macro: CEESPU_FETCH_PERF_EN.
- Defined:
  - O_fetchCount increments on every pop, wrapping at 2^32.
  - O_flushCount increments on every cycle with I_branch=1, wrapping at 2^16.
  - Both clear on reset.
- Undefined: both ports are tied to constant 0 and no counter flops exist.

Decomposition:
- Package ceespu_pkg:
  - INSTR_W and PC_W defaults, RESET_PC default.
  - A fetch-entry struct typedef {instr, pc}.
- Sub-module ceespu_fetch_fifo:
  - Generic DEPTH x entry FIFO with push, pop, flush, count; pointers wrap modulo DEPTH.
- ceespu_fetch keeps the PC, the in-flight flag, the issue/discard logic and the counters.

Test Plan:
1. Release reset, I_ready=1, imem model returns address as data → O_imemAddress 0x0000, 0x0004, 0x0008 on consecutive cycles; O_valid from 2 cycles after the first issue; O_instrPC 0, 1, 2 back-to-back.
2. DEPTH=4, I_ready=0 → exactly 4 issues then O_imemE=0; head holds PC 0 unchanged. Raise I_ready → PCs 0..3 drain in order and issue resumes in the first pop cycle.
3. 3 entries queued and a read in flight returning 0xDEADBEEF; pulse I_branch with target 0x0100 → O_valid=0 next cycle, next O_imemAddress=0x0400, O_instrPC=0x100 at t+3; 0xDEADBEEF never seen at O_instr.
4. PC_W=14, branch to 0x3FFF → fetch addresses 0xFFFC then 0x0000; O_instrPC sequence 0x3FFF, 0x0000.
5. Assert I_rst low between clock edges mid-stream → O_valid and O_imemE go 0 without a clock edge; after release, first address = {RESET_PC, 2'b00}.
6. CEESPU_FETCH_PERF_EN defined, 10 pops and 2 branches → O_fetchCount=10, O_flushCount=2. Macro undefined, same stimulus → both 0.

Source files
------------

// File: rtl/ceespu_pkg.sv
// Shared defaults and the fetch-queue entry type for the ceespu fetch unit.
package ceespu_pkg;

    localparam int PC_W_DEFAULT     = 14;
    localparam int INSTR_W_DEFAULT  = 32;
    localparam int RESET_PC_DEFAULT = 0;

    typedef struct packed {
        logic [INSTR_W_DEFAULT-1:0] instr;
        logic [PC_W_DEFAULT-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/ceespu_fetch_fifo.sv
// Generic DEPTH-entry FIFO with push, pop, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module ceespu_fetch_fifo
    import ceespu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  entry_t                 data_i,
    output entry_t                 data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_eff;
    logic          full;
    entry_t        mem_q [DEPTH];

    assign empty_o = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign pop_eff = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i)  wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_eff) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_eff);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // A full queue may only accept a push in the same cycle it pops.
            if (push_i && !pop_eff && !flush_i) assert (!full);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ceespu_fetch.sv
// Fetch unit: PC, imem read issue, prefetch queue and valid/ready delivery to decode.
// Optional performance counters are built when CEESPU_FETCH_PERF_EN is defined.
module ceespu_fetch
    import ceespu_pkg::*;
#(
    parameter int PC_W     = PC_W_DEFAULT,
    parameter int INSTR_W  = INSTR_W_DEFAULT,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_branch,
    input  logic [PC_W-1:0]    I_branchAddress,
    output logic [PC_W+1:0]    O_imemAddress,
    output logic               O_imemE,
    input  logic [INSTR_W-1:0] I_imemData,
    output logic               O_valid,
    input  logic               I_ready,
    output logic [INSTR_W-1:0] O_instr,
    output logic [PC_W-1:0]    O_instrPC,
    output logic [31:0]        O_fetchCount,
    output logic [15:0]        O_flushCount
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] inflight_pc_q;
    logic            inflight_q;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            empty, pop, push, issue;
    entry_t          push_entry, head;

    assign push_entry = '{instr: I_imemData, pc: inflight_pc_q};

    ceespu_fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (I_clk),
        .rst_ni  (I_rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (I_branch),
        .data_i  (push_entry),
        .data_o  (head),
        .count_o (count),
        .empty_o (empty)
    );

    assign O_valid   = !empty;
    assign O_instr   = O_valid ? head.instr : '0;
    assign O_instrPC = O_valid ? head.pc : '0;
    assign pop       = O_valid && I_ready;

    // A response returning during a redirect cycle belongs to the old stream.
    assign push = inflight_q && !I_branch;

    // Slots already promised: queued entries plus the pending response, minus this cycle's pop.
    assign occupancy = {1'b0, count} + {CW'(0), inflight_q} - {CW'(0), pop};
    assign issue     = I_rst && !I_branch && (occupancy < (CW+1)'(DEPTH));

    assign O_imemE       = issue;
    assign O_imemAddress = {pc_q, 2'b00};

    always_comb begin
        pc_d = pc_q;
        if (I_branch)   pc_d = I_branchAddress;
        else if (issue) pc_d = pc_q + 1'b1;
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            pc_q          <= PC_W'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= issue;
            inflight_pc_q <= pc_q;
        end
    end

`ifdef CEESPU_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pop)      fetch_cnt_q <= fetch_cnt_q + 1'b1;
            if (I_branch) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign O_fetchCount = fetch_cnt_q;
    assign O_flushCount = flush_cnt_q;
`else
    assign O_fetchCount = '0;
    assign O_flushCount = '0;
`endif

endmodule

// File: tb/tb_ceespu_fetch.sv
// Self-checking bench for ceespu_fetch against a queue-based reference model.
module tb_ceespu_fetch;

    localparam int PC_W     = 14;
    localparam int INSTR_W  = 32;
    localparam int DEPTH    = 4;
    localparam int RESET_PC = 0;
`ifdef CEESPU_FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic               I_clk = 1'b0;
    logic               I_rst;
    logic               I_branch;
    logic [PC_W-1:0]    I_branchAddress;
    logic [PC_W+1:0]    O_imemAddress;
    logic               O_imemE;
    logic [INSTR_W-1:0] I_imemData;
    logic               O_valid;
    logic               I_ready;
    logic [INSTR_W-1:0] O_instr;
    logic [PC_W-1:0]    O_instrPC;
    logic [31:0]        O_fetchCount;
    logic [15:0]        O_flushCount;

    ceespu_fetch #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .I_clk           (I_clk),
        .I_rst           (I_rst),
        .I_branch        (I_branch),
        .I_branchAddress (I_branchAddress),
        .O_imemAddress   (O_imemAddress),
        .O_imemE         (O_imemE),
        .I_imemData      (I_imemData),
        .O_valid         (O_valid),
        .I_ready         (I_ready),
        .O_instr         (O_instr),
        .O_instrPC       (O_instrPC),
        .O_fetchCount    (O_fetchCount),
        .O_flushCount    (O_flushCount)
    );

    always #5 I_clk = ~I_clk;

    int nchk  = 0;
    int nfail = 0;
    logic poison = 1'b0;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    // Instruction memory: data for an accepted read appears one cycle later.
    always @(posedge I_clk) begin
        if (O_imemE) I_imemData <= poison ? 32'hDEADBEEF : mem_word(O_imemAddress);
        else         I_imemData <= 32'hBAD0BAD0;
    end

    typedef struct {
        logic [31:0] instr;
        logic [13:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [13:0] m_pc;
    logic        m_infl;
    logic [13:0] m_infl_pc;
    logic [31:0] m_infl_data;
    logic [31:0] m_fc;
    logic [15:0] m_flc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc        = 14'(RESET_PC);
        m_infl      = 1'b0;
        m_infl_pc   = '0;
        m_infl_data = '0;
        m_fc        = '0;
        m_flc       = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(O_valid), 64'd0);
        chk({tag, "_imemE"}, 64'(O_imemE), 64'd0);
        chk({tag, "_instr"}, 64'(O_instr), 64'd0);
        chk({tag, "_instrPC"}, 64'(O_instrPC), 64'd0);
        chk({tag, "_fetchCount"}, 64'(O_fetchCount), 64'd0);
        chk({tag, "_flushCount"}, 64'(O_flushCount), 64'd0);
    endtask

    // One clock cycle: entered and left just after a falling edge.
    task automatic cycle(input logic br, input logic [13:0] ba, input logic rdy);
        logic        exp_valid, pop, issue;
        logic [31:0] exp_instr;
        logic [13:0] exp_pc;
        int          occ;
        I_branch        = br;
        I_branchAddress = ba;
        I_ready         = rdy;
        #2;
        exp_valid = (mq.size() > 0);
        exp_instr = exp_valid ? mq[0].instr : 32'd0;
        exp_pc    = exp_valid ? mq[0].pc : 14'd0;
        pop       = exp_valid && rdy;
        occ       = mq.size() + int'(m_infl) - int'(pop);
        issue     = !br && (occ < DEPTH);

        chk("valid", 64'(O_valid), 64'(exp_valid));
        chk("instr", 64'(O_instr), 64'(exp_instr));
        chk("instrPC", 64'(O_instrPC), 64'(exp_pc));
        chk("imemE", 64'(O_imemE), 64'(issue));
        if (issue) chk("imemAddress", 64'(O_imemAddress), 64'({m_pc, 2'b00}));
        chk("fetchCount", 64'(O_fetchCount), PERF ? 64'(m_fc) : 64'd0);
        chk("flushCount", 64'(O_flushCount), PERF ? 64'(m_flc) : 64'd0);

        if (pop) begin
            void'(mq.pop_front());
            m_fc++;
        end
        if (m_infl && !br) mq.push_back('{instr: m_infl_data, pc: m_infl_pc});
        if (br) begin
            mq.delete();
            m_flc++;
        end
        m_infl      = issue;
        m_infl_pc   = m_pc;
        m_infl_data = poison ? 32'hDEADBEEF : mem_word({m_pc, 2'b00});
        if (br)         m_pc = ba;
        else if (issue) m_pc = m_pc + 14'd1;

        @(posedge I_clk);
        @(negedge I_clk);
    endtask

    // Reset pulled between clock edges; outputs must clear before any edge.
    task automatic mid_reset(input string tag);
        #2 I_rst = 1'b0;
        #1 chk_reset_outputs(tag);
        model_reset();
        @(posedge I_clk);
        @(negedge I_clk);
        I_rst = 1'b1;
    endtask

    initial begin
        I_rst           = 1'b0;
        I_branch        = 1'b0;
        I_branchAddress = '0;
        I_ready         = 1'b0;
        model_reset();
        repeat (2) @(posedge I_clk);
        @(negedge I_clk);
        #1 chk_reset_outputs("por");
        I_rst = 1'b1;

        // Streaming with decode always ready.
        repeat (8) cycle(1'b0, 14'd0, 1'b1);

        // Decode stalled: queue fills, head holds PC 0, then drains.
        mid_reset("rst_t2");
        repeat (7) cycle(1'b0, 14'd0, 1'b0);
        chk("t2_headpc", 64'(O_instrPC), 64'd0);
        chk("t2_stalled_imemE", 64'(O_imemE), 64'd0);
        repeat (8) cycle(1'b0, 14'd0, 1'b1);

        // Three queued plus a poisoned read in flight, then redirect to 0x100.
        cycle(1'b1, 14'h020, 1'b0);
        repeat (3) cycle(1'b0, 14'd0, 1'b0);
        poison = 1'b1;
        cycle(1'b0, 14'd0, 1'b0);
        poison = 1'b0;
        cycle(1'b1, 14'h100, 1'b0);
        chk("t3_valid_after_branch", 64'(O_valid), 64'd0);
        repeat (8) begin
            chk("t3_no_deadbeef", 64'(O_instr == 32'hDEADBEEF), 64'd0);
            cycle(1'b0, 14'd0, 1'b1);
        end

        // PC wrap from the top of the word address space.
        cycle(1'b1, 14'h3FFF, 1'b1);
        chk("t4_target_addr", 64'(O_imemAddress), 64'hFFFC);
        repeat (6) cycle(1'b0, 14'd0, 1'b1);

        // Reset mid-stream.
        mid_reset("rst_t5");
        chk("t5_first_addr", 64'(O_imemAddress), 64'({14'(RESET_PC), 2'b00}));
        repeat (6) cycle(1'b0, 14'd0, 1'b1);

        // Counter scenario: two redirects among a stream of pops.
        mid_reset("rst_t6");
        repeat (5) cycle(1'b0, 14'd0, 1'b1);
        cycle(1'b1, 14'h040, 1'b1);
        repeat (5) cycle(1'b0, 14'd0, 1'b1);
        cycle(1'b1, 14'h080, 1'b1);
        repeat (6) cycle(1'b0, 14'd0, 1'b1);

        // Randomised traffic with occasional redirects and one reset.
        for (int i = 0; i < 400; i++) begin
            logic        br, rdy;
            logic [13:0] ba;
            if (i == 200) mid_reset("rst_rand");
            br  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            ba  = ($urandom_range(0, 3) == 0) ? 14'(14'h3FFC + $urandom_range(0, 3))
                                              : 14'($urandom);
            cycle(br, ba, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
